// File: rtl/encoder_arbiter.sv
// Two-requester round-robin arbiter sharing one 8->12 bit encoder, feeding a
// single registered output slot with per-requester saturating served counters.
module encoder_arbiter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [7:0]           req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [7:0]           req1_data,
  output logic                 req1_ready,
  output logic                 out_valid,
  output logic [11:0]          out_codeword,
  output logic                 out_id,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] served0,
  output logic [CNT_WIDTH-1:0] served1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [11:0]          cw_q, cw_d;
  logic                 id_q, id_d;
  logic                 last_q, last_d;
  logic [CNT_WIDTH-1:0] served0_q, served0_d;
  logic [CNT_WIDTH-1:0] served1_q, served1_d;

  logic       slot_free;
  logic       grant0, grant1;
  logic       hs0, hs1;
  logic [7:0] sel_data;

  assign slot_free = (state_q == EMPTY) || out_ready;

  // On a tie, the requester not recorded in last_q wins.
  assign grant0 = req0_valid && (!req1_valid || last_q);
  assign grant1 = req1_valid && (!req0_valid || !last_q);

  assign req0_ready = !rst && slot_free && grant0;
  assign req1_ready = !rst && slot_free && grant1;

  assign hs0 = req0_valid && req0_ready;
  assign hs1 = req1_valid && req1_ready;

  assign sel_data = hs1 ? req1_data : req0_data;

  always_comb begin
    state_d   = state_q;
    cw_d      = cw_q;
    id_d      = id_q;
    last_d    = last_q;
    served0_d = served0_q;
    served1_d = served1_q;
    if (hs0 || hs1) begin
      state_d = FULL;
      cw_d    = {sel_data, sel_data[3:0]};
      id_d    = hs1;
      last_d  = hs1;
      if (hs0 && (served0_q != '1)) served0_d = served0_q + 1'b1;
      if (hs1 && (served1_q != '1)) served1_d = served1_q + 1'b1;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      cw_q      <= '0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      served0_q <= '0;
      served1_q <= '0;
    end else begin
      state_q   <= state_d;
      cw_q      <= cw_d;
      id_q      <= id_d;
      last_q    <= last_d;
      served0_q <= served0_d;
      served1_q <= served1_d;
    end
  end

  assign out_valid    = (state_q == FULL);
  assign out_codeword = cw_q;
  assign out_id       = id_q;
  assign served0      = served0_q;
  assign served1      = served1_q;

endmodule

// File: tb/tb_encoder_arbiter.sv
// Self-checking bench for encoder_arbiter: vector table, streaming scoreboard,
// and a narrow-counter instance for saturation.
module tb_encoder_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, out_ready;
  logic [7:0]  req0_data, req1_data;
  logic        req0_ready, req1_ready, out_valid, out_id;
  logic [11:0] out_codeword;
  logic [15:0] served0, served1;

  logic        rst2, v0_2, v1_2, ordy2;
  logic [7:0]  d0_2, d1_2;
  logic        r0_2, r1_2, ov_2, id_2;
  logic [11:0] cw_2;
  logic [1:0]  s0_2, s1_2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encoder_arbiter #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_codeword(out_codeword), .out_id(out_id),
    .out_ready(out_ready), .served0(served0), .served1(served1)
  );

  encoder_arbiter #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst2),
    .req0_valid(v0_2), .req0_data(d0_2), .req0_ready(r0_2),
    .req1_valid(v1_2), .req1_data(d1_2), .req1_ready(r1_2),
    .out_valid(ov_2), .out_codeword(cw_2), .out_id(id_2),
    .out_ready(ordy2), .served0(s0_2), .served1(s1_2)
  );

  typedef struct {
    logic        rst;
    logic        v0;
    logic [7:0]  d0;
    logic        v1;
    logic [7:0]  d1;
    logic        ordy;
    logic        r0;
    logic        r1;
    logic        ov;
    logic [11:0] cw;
    logic        id;
    logic [15:0] s0;
    logic [15:0] s1;
  } vec_t;

  typedef struct {
    logic [11:0] cw;
    logic        id;
  } exp_t;

  vec_t vecs[15];
  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    //        rst  v0  d0     v1  d1     ordy r0 r1 ov  cw        id s0 s1
    vecs[0]  = '{1, 1, 8'hAA, 0, 8'h00, 1,   0, 0, 0, 12'h000, 0, 0, 0};
    vecs[1]  = '{0, 1, 8'hAA, 0, 8'h00, 1,   1, 0, 1, 12'hAAA, 0, 1, 0};
    vecs[2]  = '{0, 0, 8'h00, 1, 8'h5C, 0,   0, 0, 1, 12'hAAA, 0, 1, 0};
    vecs[3]  = '{0, 0, 8'h00, 1, 8'h5C, 0,   0, 0, 1, 12'hAAA, 0, 1, 0};
    vecs[4]  = '{0, 0, 8'h00, 1, 8'h5C, 0,   0, 0, 1, 12'hAAA, 0, 1, 0};
    vecs[5]  = '{0, 0, 8'h00, 1, 8'h5C, 1,   0, 1, 1, 12'h5CC, 1, 1, 1};
    vecs[6]  = '{0, 0, 8'h77, 0, 8'h66, 1,   0, 0, 0, 12'h000, 0, 1, 1};
    vecs[7]  = '{0, 0, 8'h00, 1, 8'h3F, 0,   0, 1, 1, 12'h3FF, 1, 1, 2};
    vecs[8]  = '{0, 1, 8'h11, 0, 8'h00, 0,   0, 0, 1, 12'h3FF, 1, 1, 2};
    vecs[9]  = '{1, 1, 8'h11, 1, 8'h22, 0,   0, 0, 0, 12'h000, 0, 0, 0};
    vecs[10] = '{0, 1, 8'h12, 1, 8'h34, 0,   1, 0, 1, 12'h122, 0, 1, 0};
    vecs[11] = '{0, 1, 8'h12, 1, 8'h34, 1,   0, 1, 1, 12'h344, 1, 1, 1};
    vecs[12] = '{1, 0, 8'h00, 0, 8'h00, 0,   0, 0, 0, 12'h000, 0, 0, 0};
    vecs[13] = '{0, 0, 8'hFF, 1, 8'h34, 0,   0, 1, 1, 12'h344, 1, 0, 1};
    vecs[14] = '{0, 0, 8'hE1, 0, 8'hD2, 1,   0, 0, 0, 12'h000, 0, 0, 1};

    rst = 1'b1; req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0; out_ready = 0;
    rst2 = 1'b1; v0_2 = 0; v1_2 = 0; d0_2 = '0; d1_2 = '0; ordy2 = 0;

    // Vector table: readys checked before the edge, registered outputs after.
    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      req0_valid = vecs[i].v0; req0_data = vecs[i].d0;
      req1_valid = vecs[i].v1; req1_data = vecs[i].d1;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d req0_ready", i), int'(req0_ready), int'(vecs[i].r0));
      check($sformatf("vec%0d req1_ready", i), int'(req1_ready), int'(vecs[i].r1));
      @(posedge clk); #1;
      check($sformatf("vec%0d out_valid", i), int'(out_valid), int'(vecs[i].ov));
      if (vecs[i].ov || vecs[i].rst) begin
        check($sformatf("vec%0d out_codeword", i), int'(out_codeword), int'(vecs[i].cw));
        check($sformatf("vec%0d out_id", i), int'(out_id), int'(vecs[i].id));
      end
      check($sformatf("vec%0d served0", i), int'(served0), int'(vecs[i].s0));
      check($sformatf("vec%0d served1", i), int'(served1), int'(vecs[i].s1));
    end

    // Streaming round-robin with both requesters always valid.
    @(negedge clk);
    rst = 1'b1; req0_valid = 0; req1_valid = 0; out_ready = 1;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      exp_t e;
      @(negedge clk);
      rst = 1'b0;
      req0_valid = 1; req0_data = 8'h12;
      req1_valid = 1; req1_data = 8'h34;
      out_ready = 1;
      e.id = k[0];
      e.cw = e.id ? 12'h344 : 12'h122;
      sb.push_back(e);
      #1;
      check($sformatf("rr%0d req0_ready", k), int'(req0_ready), int'(!e.id));
      check($sformatf("rr%0d req1_ready", k), int'(req1_ready), int'(e.id));
      @(posedge clk); #1;
      if (!out_valid) begin
        check($sformatf("rr%0d bubble", k), int'(out_valid), 1);
      end else if (sb.size() == 0) begin
        check($sformatf("rr%0d unexpected output", k), int'(sb.size()), 1);
      end else begin
        exp_t g;
        g = sb.pop_front();
        check($sformatf("rr%0d codeword", k), int'(out_codeword), int'(g.cw));
        check($sformatf("rr%0d id", k), int'(out_id), int'(g.id));
      end
    end
    check("rr scoreboard drained", sb.size(), 0);
    check("rr served0", int'(served0), 6);
    check("rr served1", int'(served1), 6);

    // Narrow counters saturate at 3.
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    rst2 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      rst2 = 1'b0; v0_2 = 1; d0_2 = 8'(k); ordy2 = 1;
      #1;
      check($sformatf("sat%0d ready", k), int'(r0_2), 1);
      @(posedge clk); #1;
      check($sformatf("sat%0d served0", k), int'(s0_2), (k > 3) ? 3 : k);
      check($sformatf("sat%0d served1", k), int'(s1_2), 0);
      check($sformatf("sat%0d codeword", k), int'(cw_2), int'({8'(k), 4'(k)}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_arbiter.md
ENCODER_ARBITER -- requirements
Module: encoder_arbiter

Interface
REQ-001 SHALL have parameter: CNT_WIDTH, default 16, width of each per-requester served counter.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req0_valid  input  1  requester 0 offers a data word.
REQ-005 SHALL have port: req0_data  input  8  requester 0 data word.
REQ-006 SHALL have port: req0_ready  output  1  requester 0 word accepted this cycle.
REQ-007 SHALL have port: req1_valid  input  1  requester 1 offers a data word.
REQ-008 SHALL have port: req1_data  input  8  requester 1 data word.
REQ-009 SHALL have port: req1_ready  output  1  requester 1 word accepted this cycle.
REQ-010 SHALL have port: out_valid  output  1  registered codeword available.
REQ-011 SHALL have port: out_codeword  output  12  encoded word.
REQ-012 SHALL have port: out_id  output  1  index of the requester that produced out_codeword.
REQ-013 SHALL have port: out_ready  input  1  downstream consumes the codeword this cycle.
REQ-014 SHALL have ports: served0, served1  output  CNT_WIDTH  accepted-word counts per requester.

Function
REQ-015 SHALL share one encoder between both requesters, with codeword = {data[7:0], data[3:0]}: data in bits 11:4, data low nibble in bits 3:0.
REQ-016 SHALL hold one output slot with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 SHALL define slot_free = (state==EMPTY) or out_ready; slot_free is combinational.
REQ-018 SHALL grant only a requester whose valid is high: grant to the sole valid requester; when both are valid, grant to the one not recorded in last_served (round-robin).
REQ-019 SHALL drive reqN_ready = slot_free AND grantN; at most one ready high per cycle; both low when neither is valid.
REQ-020 SHALL, on handshake (reqN_valid and reqN_ready), load out_codeword with the encoded reqN_data, load out_id=N, and go to FULL at the next edge; latency is exactly 1 cycle.
REQ-021 SHALL, on the same handshake, set last_served=N and increment servedN, saturating at 2^CNT_WIDTH-1 with no wrap.
REQ-022 SHALL, in FULL with out_ready=1 and no new handshake, return to EMPTY at the next edge.
REQ-023 SHALL, in FULL with out_ready=1 and a simultaneous handshake, stay FULL and replace the slot contents back-to-back (no bubble).
REQ-024 SHALL hold out_codeword and out_id stable while out_valid=1 and out_ready=0; both req readys are 0 in that case.
REQ-025 SHALL leave last_served and the counters unchanged in any cycle with no handshake.
REQ-026 SHALL ignore req data while the matching valid is low; out_ready is ignored in EMPTY.

Reset
REQ-027 SHALL, when rst=1 at an edge, set state=EMPTY, out_valid=0, out_codeword=0, out_id=0, served0=served1=0, last_served=1 (req0 wins the first tie).
REQ-028 SHALL, on reset during FULL or stall, discard the pending codeword with no handshake credited.
REQ-029 SHALL force req0_ready=req1_ready=0 in any cycle where rst=1.

Verification
REQ-030 SHALL cover: req0_valid=1, data 0xAA, out_ready=1 -> next cycle out_valid=1, out_codeword=0xAAA, out_id=0, served0=1.
REQ-031 SHALL cover: both valid continuously, req0=0x12, req1=0x34, out_ready=1, after reset -> outputs 0x122/id0, 0x344/id1, 0x122/id0, ... one per cycle, no bubbles.
REQ-032 SHALL cover: out_ready=0 while FULL for 3 cycles -> both readys 0, output stable; out_ready=1 with req1 valid -> same-cycle refill, next out_id=1.
REQ-033 SHALL cover: CNT_WIDTH=2, five req0 handshakes -> served0=3 (saturated), served1=0.
REQ-034 SHALL cover: rst=1 while FULL and stalled -> next cycle out_valid=0, counters 0; then both valid -> req0 granted first.
REQ-035 SHALL cover: only req1 valid with last_served=1 -> req1 granted (no idle waiting for req0).
